// File: rtl/branch_resolve_unit_if.sv
// Request/result handshake bundle for branch_resolve_unit.
// The master side issues requests and consumes results; the slave side is the unit.
interface branch_resolve_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_kind;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_data1;
    logic [XLEN-1:0] in_data2;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic [XLEN-1:0] in_pred_target;

    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic            out_mispredict;
    logic            out_illegal;
    logic            out_less;
    logic            out_equal;

    modport master (
        output in_valid, in_kind, in_funct3, in_data1, in_data2, in_pc, in_imm,
        output in_pred_taken, in_pred_target, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_mispredict, out_illegal,
        input  out_less, out_equal
    );

    modport slave (
        input  in_valid, in_kind, in_funct3, in_data1, in_data2, in_pc, in_imm,
        input  in_pred_taken, in_pred_target, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_mispredict, out_illegal,
        output out_less, out_equal
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: compare, target generation, misprediction check,
// 1- or 2-deep valid/ready pipeline with flush and saturating statistics counters.
module branch_resolve_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    branch_resolve_unit_if.slave bus,
    output logic [CNT_W-1:0]     branch_cnt,
    output logic [CNT_W-1:0]     mispredict_cnt
);
    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;

    if ((STAGES != 1 && STAGES != 2) || XLEN < 8) begin : g_bad_params
        $error("branch_resolve_unit: STAGES must be 1 or 2 and XLEN at least 8");
    end

    logic [XLEN:0]   diff_ext;
    logic [XLEN-1:0] jalr_sum;
    logic            lt_u, lt_s;
    logic            c_equal, c_less, c_taken, c_illegal;
    logic [XLEN-1:0] c_target;

    always_comb begin
        diff_ext  = {1'b0, bus.in_data1} - {1'b0, bus.in_data2};
        lt_u      = diff_ext[XLEN];
        lt_s      = (bus.in_data1[XLEN-1] != bus.in_data2[XLEN-1]) ? bus.in_data1[XLEN-1]
                                                                   : diff_ext[XLEN-1];
        // A zero difference is exactly operand equality.
        c_equal   = (diff_ext[XLEN-1:0] == '0);
        c_less    = bus.in_funct3[1] ? lt_u : lt_s;
        jalr_sum  = bus.in_data1 + bus.in_imm;
        c_taken   = 1'b0;
        c_illegal = 1'b0;
        c_target  = bus.in_pc + bus.in_imm;
        case (bus.in_kind)
            KIND_BR: begin
                case (bus.in_funct3)
                    3'b000:          c_taken = c_equal;
                    3'b001:          c_taken = !c_equal;
                    3'b100, 3'b110:  c_taken = c_less;
                    3'b101, 3'b111:  c_taken = !c_less;
                    default:         c_illegal = 1'b1;
                endcase
            end
            KIND_JAL:  c_taken = 1'b1;
            KIND_JALR: begin
                c_taken  = 1'b1;
                c_target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
            end
            default: begin
                c_illegal = 1'b1;
                c_target  = '0;
            end
        endcase
    end

    // Signals feeding the output register, either straight from the inputs or from stage A.
    logic            m_valid, m_less, m_equal, m_taken, m_illegal, m_pred_taken, m_mispredict;
    logic [XLEN-1:0] m_target, m_pred_target;

    logic            out_valid_q, out_taken_q, out_mispredict_q, out_illegal_q;
    logic            out_less_q, out_equal_q;
    logic [XLEN-1:0] out_target_q;
    logic            out_adv;

    assign out_adv = !out_valid_q || bus.out_ready;

    if (STAGES == 2) begin : g_two
        logic            a_valid_q, a_less_q, a_equal_q, a_taken_q, a_illegal_q, a_pred_taken_q;
        logic [XLEN-1:0] a_target_q, a_pred_target_q;

        assign bus.in_ready = !flush && (!a_valid_q || out_adv);

        always_ff @(posedge clk) begin
            if (rst) begin
                a_valid_q       <= 1'b0;
                a_less_q        <= 1'b0;
                a_equal_q       <= 1'b0;
                a_taken_q       <= 1'b0;
                a_illegal_q     <= 1'b0;
                a_pred_taken_q  <= 1'b0;
                a_target_q      <= '0;
                a_pred_target_q <= '0;
            end else if (flush) begin
                a_valid_q <= 1'b0;
            end else if (!a_valid_q || out_adv) begin
                a_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    a_less_q        <= c_less;
                    a_equal_q       <= c_equal;
                    a_taken_q       <= c_taken;
                    a_illegal_q     <= c_illegal;
                    a_pred_taken_q  <= bus.in_pred_taken;
                    a_target_q      <= c_target;
                    a_pred_target_q <= bus.in_pred_target;
                end
            end
        end

        assign m_valid       = a_valid_q;
        assign m_less        = a_less_q;
        assign m_equal       = a_equal_q;
        assign m_taken       = a_taken_q;
        assign m_illegal     = a_illegal_q;
        assign m_pred_taken  = a_pred_taken_q;
        assign m_target      = a_target_q;
        assign m_pred_target = a_pred_target_q;
    end else begin : g_one
        assign bus.in_ready  = !flush && out_adv;
        assign m_valid       = bus.in_valid;
        assign m_less        = c_less;
        assign m_equal       = c_equal;
        assign m_taken       = c_taken;
        assign m_illegal     = c_illegal;
        assign m_pred_taken  = bus.in_pred_taken;
        assign m_target      = c_target;
        assign m_pred_target = bus.in_pred_target;
    end

    assign m_mispredict = !m_illegal &&
                          ((m_taken != m_pred_taken) || (m_taken && (m_target != m_pred_target)));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_mispredict_q <= 1'b0;
            out_illegal_q    <= 1'b0;
            out_less_q       <= 1'b0;
            out_equal_q      <= 1'b0;
            out_target_q     <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (out_adv) begin
            out_valid_q <= m_valid;
            if (m_valid) begin
                out_taken_q      <= m_taken;
                out_mispredict_q <= m_mispredict;
                out_illegal_q    <= m_illegal;
                out_less_q       <= m_less;
                out_equal_q      <= m_equal;
                out_target_q     <= m_target;
            end
        end
    end

    logic out_hs;
    assign out_hs = out_valid_q && bus.out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (out_hs) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (out_mispredict_q && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + 1'b1;
            end
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_taken      = out_taken_q;
    assign bus.out_target     = out_target_q;
    assign bus.out_mispredict = out_mispredict_q;
    assign bus.out_illegal    = out_illegal_q;
    assign bus.out_less       = out_less_q;
    assign bus.out_equal      = out_equal_q;
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined, parametrised branch resolution unit for the execute stage of the RISC-V core. It compares two XLEN-wide operands for all six conditional-branch funct3 encodings and computes the branch/jump target. It checks the front-end prediction and reports misprediction through a valid/ready handshake. It supports 1 or 2 internal register stages, a pipeline flush, and saturating branch/mispredict statistics counters.

## Interface
- XLEN, 32: operand, PC and target width (≥ 8).
- STAGES, 1: internal register stages, 1 or 2; any other value is a elaboration error.
- CNT_W, 32: width of statistics counters.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit accepts request this cycle.
- in_kind  in  2  00 conditional branch, 01 JAL, 10 JALR, 11 reserved (treated as illegal).
- in_funct3  in  3  branch condition (used only for in_kind=00).
- in_data1, in_data2  in  XLEN  rs1, rs2 values.
- in_pc, in_imm  in  XLEN  instruction PC, sign-extended immediate.
- in_pred_taken  in  1  front-end predicted direction.
- in_pred_target  in  XLEN  front-end predicted target.
- flush  in  1  kill all in-flight entries.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_taken  out  1  resolved direction.
- out_target  out  XLEN  resolved target (valid even if not taken).
- out_mispredict  out  1  prediction wrong.
- out_illegal  out  1  funct3 010/011 or in_kind=11.
- out_less, out_equal  out  1  raw compare flags (signedness per funct3[1]).
- branch_cnt, mispredict_cnt  out  CNT_W  statistics.

## Operation
- equal = (data1 == data2).
- Unsigned less = borrow out of the XLEN+1-bit subtraction {0,data1} − {0,data2}.
- Signed less: if the sign bits differ, less = data1[XLEN-1]; otherwise less = the sign of (data1 − data2).
- out_less uses unsigned when funct3[1]=1, otherwise signed.
- Taken, kind 00: BEQ 000 = eq; BNE 001 = !eq; BLT 100 / BLTU 110 = less; BGE 101 / BGEU 111 = !less; 010/011 → taken=0, illegal=1.
- Taken, kind 01/10: taken=1, no compare used. Kind 11: taken=0, illegal=1.
- Target: kinds 00/01 = in_pc + in_imm (mod 2^XLEN); kind 10 = (in_data1 + in_imm) with bit 0 cleared; kind 11 = 0.
- Mispredict = (taken ≠ pred_taken) OR (taken AND target ≠ pred_target). It is forced to 0 when illegal.
- Pipeline placement:
  - STAGES=1: all logic feeds one output register.
  - STAGES=2: stage A registers compare flags, taken and target; stage B computes mispredict and registers the outputs.
- Each stage holds a valid bit and advances when its successor is empty or draining.
- in_ready = !flush AND (first stage empty OR first stage advancing).
- Flush: all stage valid bits clear on the next edge. An in_valid presented in the flush cycle is not accepted. flush has priority over every handshake.
- Counters update on output handshake (out_valid && out_ready && !flush):
  - branch_cnt increments on every handshake.
  - mispredict_cnt increments when out_mispredict=1.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Illegal entries are counted in branch_cnt.

## Timing
- Reset: all valid bits 0, so out_valid=0; in_ready=1 the cycle after reset deasserts; every data output is 0; both counters are 0.
- Reset applied mid-operation discards all entries identically to flush and also clears the counters.
- Latency: accept at edge N → out_valid at edge N+STAGES.
- Throughput: 1 result/cycle while out_ready=1.
- While out_valid=1 and out_ready=0, all out_* are held stable.
- Full pipeline with out_ready=0 → in_ready=0 in the same cycle (combinational from out_ready).
- Simultaneous out handshake and input accept when full: allowed; no bubble.

## Test plan
- Compare sweep, XLEN=32: data1=0xFFFFFFFF, data2=0x00000001. BLT → taken=1, BLTU → taken=0, BGE → 0, BGEU → 1. Equal operands 0x80000000: BEQ=1, BNE=0, BLT=0, BGE=1.
- Targets: JALR with data1=0x1001, imm=0x4 → target 0x1004, taken=1. Branch with pc=0x100, imm=0xFFFFFFF0 → target 0xF0.
- Mispredict: BEQ taken with pred_taken=1 and pred_target≠target → mispredict=1, mispredict_cnt+1. Same case with matching target → 0. funct3=010 → illegal=1, mispredict=0, branch_cnt+1.
- Backpressure, STAGES=2: stream 5 back-to-back requests with out_ready low for cycles 3–6.
  - in_ready drops once 2 entries are held.
  - Outputs stay stable while stalled.
  - All 5 results emerge in order, none lost or duplicated.
- Flush/reset: flush while 2 entries are in flight and in_valid=1 → out_valid=0 next cycle, the input is not accepted, counters are unchanged. rst mid-stream → counters 0, out_valid=0.
- Saturation, CNT_W=4: 20 mispredicted handshakes → both counters hold at 15.
